// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline stall scheduler: stall-bus type and
//   bit meanings, canned stall patterns, and the scheduler state encoding.
//   Stall bus bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB (1 = Stop).
// ----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   localparam int unsigned STALL_BUS_W = 6;

   typedef logic [STALL_BUS_W-1:0] stall_bus_t;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam stall_bus_t STALL_NONE = 6'b000000;
   // PC/IF/ID held; EX is fed a bubble from ID.
   localparam stall_bus_t STALL_LDU  = 6'b000111;
   // PC/IF/ID/EX frozen while the multiplier/divider works.
   localparam stall_bus_t STALL_MD   = 6'b001111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LDU  = 2'd1,
      ST_MD   = 2'd2
   } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_md_lat_counter.sv
// ----------------------------------------------------------------------------
// md_lat_counter
//   Loadable down-counter tracking the remaining mult/div stall cycles.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     load       load load_val (has priority over dec)
//     load_val   value to load
//     dec        decrement by one (saturates at 0)
//     clr        clear to 0 (highest priority)
//     last       count == 1
// ----------------------------------------------------------------------------
module md_lat_counter #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   input  logic             clr,
   output logic             last
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign last = (count == CNT_W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall scheduler for the 5-stage pipeline. Inserts one bubble for a
//   load-use hazard (load in EX feeding the instruction in ID) and freezes
//   PC/IF/ID/EX for a fixed latency while a mult/div runs in EX.
//   Ports:
//     clk, rst                clock, asynchronous active-high reset
//     id_rs/id_rs_used        rs field of ID instruction and its use flag
//     id_rt/id_rt_used        rt field of ID instruction and its use flag
//     ex_valid                EX holds a real instruction
//     ex_is_load              EX instruction is a load
//     ex_waddr                EX destination register
//     ex_md_start             EX instruction is mult/multu/mul/div/divu
//     ex_md_is_div            select DIV_LAT (1) or MUL_LAT (0)
//     flush                   abort an in-flight mult/div sequence
//     stall                   stall bus to every stage register
//     md_busy                 mult/div sequence active
//     md_done                 last stall cycle of a mult/div
//     ldu_stall_cnt           load-use bubbles inserted
//     md_stall_cnt            mult/div stall cycles
//   Build option: define HAZARD_PERF_CNT_EN to enable the two performance
//   counters; otherwise they read constant zero.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned STALL_W = 6,
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned DIV_LAT = 33,
   parameter int unsigned CNT_W   = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         id_rs,
   input  logic               id_rs_used,
   input  logic [4:0]         id_rt,
   input  logic               id_rt_used,
   input  logic               ex_valid,
   input  logic               ex_is_load,
   input  logic [4:0]         ex_waddr,
   input  logic               ex_md_start,
   input  logic               ex_md_is_div,
   input  logic               flush,
   output logic [STALL_W-1:0] stall,
   output logic               md_busy,
   output logic               md_done,
   output logic [31:0]        ldu_stall_cnt,
   output logic [31:0]        md_stall_cnt
);

   localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LAT);

   hz_state_t        state, state_nxt;
   stall_bus_t       stall_bus;
   logic             ldu_hazard;
   logic [CNT_W-1:0] lat;
   logic             cnt_load, cnt_dec, cnt_clr, cnt_last;

   assign ldu_hazard = ex_valid && ex_is_load && (ex_waddr != 5'd0) &&
                       ((id_rs_used && (id_rs == ex_waddr)) ||
                        (id_rt_used && (id_rt == ex_waddr)));

   assign lat = ex_md_is_div ? DIV_L : MUL_L;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall_bus = STALL_NONE;
      md_busy   = 1'b0;
      md_done   = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_clr   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (ex_valid && ex_md_start) begin
               stall_bus = STALL_MD;
               md_busy   = 1'b1;
               if (lat == CNT_W'(1)) begin
                  md_done = 1'b1;
               end else begin
                  // Start cycle counts as stall #1, so MD runs L-1 more cycles.
                  cnt_load  = 1'b1;
                  state_nxt = ST_MD;
               end
            end else if (ldu_hazard) begin
               stall_bus = STALL_LDU;
               state_nxt = ST_LDU;
            end
         end
         ST_LDU: begin
            // Hazard deliberately not re-checked: exactly one bubble per load.
            state_nxt = ST_IDLE;
         end
         ST_MD: begin
            if (flush) begin
               cnt_clr   = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               stall_bus = STALL_MD;
               md_busy   = 1'b1;
               cnt_dec   = 1'b1;
               if (cnt_last) begin
                  md_done   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Outputs are forced quiet while reset is held, independent of inputs.
      if (rst) begin
         stall_bus = STALL_NONE;
         md_busy   = 1'b0;
         md_done   = 1'b0;
      end
   end

   assign stall = STALL_W'(stall_bus);

   md_lat_counter #(
      .CNT_W (CNT_W)
   ) u_md_lat_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (lat - CNT_W'(1)),
      .dec      (cnt_dec),
      .clr      (cnt_clr),
      .last     (cnt_last)
   );

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] ldu_cnt_q, md_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ldu_cnt_q <= '0;
         md_cnt_q  <= '0;
      end else begin
         if ((state == ST_IDLE) && (state_nxt == ST_LDU)) ldu_cnt_q <= ldu_cnt_q + 32'd1;
         if (md_busy) md_cnt_q <= md_cnt_q + 32'd1;
      end
   end

   assign ldu_stall_cnt = ldu_cnt_q;
   assign md_stall_cnt  = md_cnt_q;
`else
   assign ldu_stall_cnt = '0;
   assign md_stall_cnt  = '0;
`endif

endmodule
